// File: rtl/data_memory_store_buffer.sv
// data_memory_store_buffer: in-order store queue between the stage-4 store formatter and data memory
// Ports: store_* enqueue side (valid/ready, byte address, lane enables, lane data),
// mem_* drain side (head entry presented while mem_write_en, advanced on mem_ready),
// load_addr/fwd_* combinational youngest-wins byte forwarding, buffer_empty for fence/halt.
// Optional STORE_COALESCE_EN: a store to the youngest entry's word merges into it.
module data_memory_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        store_valid,
  output logic        store_ready,
  input  logic [31:0] store_addr,
  input  logic [3:0]  store_byte_en,
  input  logic [31:0] store_data,
  output logic        mem_write_en,
  input  logic        mem_ready,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_write_data,
  input  logic [31:0] load_addr,
  output logic [3:0]  fwd_byte_en,
  output logic [31:0] fwd_data,
  output logic        buffer_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [29:0] ent_addr [DEPTH];
  logic [3:0]  ent_be   [DEPTH];
  logic [31:0] ent_data [DEPTH];
  logic [AW-1:0] head, tail, youngest;
  logic [AW:0]   count;
  logic accept, drain, merge, alloc;
  logic unused_low_bits;
  assign unused_low_bits = ^{store_addr[1:0], load_addr[1:0]};
  assign buffer_empty = count == '0;
  assign store_ready = count != (AW+1)'(DEPTH);
  assign mem_write_en = !buffer_empty;
  assign drain = mem_write_en && mem_ready;
  // zero byte-enable stores are accepted but never occupy a slot
  assign accept = store_valid && store_ready && |store_byte_en;
  assign youngest = tail - AW'(1);
`ifdef STORE_COALESCE_EN
  // a sole entry leaving this cycle cannot absorb the store
  assign merge = accept && !buffer_empty && ent_addr[youngest] == store_addr[31:2] &&
                 !(youngest == head && drain);
`else
  assign merge = 1'b0;
`endif
  assign alloc = accept && !merge;
  assign mem_addr = mem_write_en ? ent_addr[head] : '0;
  assign mem_byte_en = mem_write_en ? ent_be[head] : '0;
  assign mem_write_data = mem_write_en ? ent_data[head] : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (alloc) tail <= tail + AW'(1);
      if (drain) head <= head + AW'(1);
      count <= count + (AW+1)'(alloc) - (AW+1)'(drain);
    end
  end
  always_ff @(posedge clk) begin
    if (alloc) begin
      ent_addr[tail] <= store_addr[31:2];
      ent_be[tail] <= store_byte_en;
      ent_data[tail] <= store_data;
    end
    if (merge) begin
      ent_be[youngest] <= ent_be[youngest] | store_byte_en;
      for (int b = 0; b < 4; b++)
        if (store_byte_en[b]) ent_data[youngest][8*b +: 8] <= store_data[8*b +: 8];
    end
  end
  // walk oldest to youngest so later matches overwrite earlier lanes
  always_comb begin
    fwd_byte_en = '0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if ((AW+1)'(i) < count && ent_addr[head + AW'(i)] == load_addr[31:2])
        for (int b = 0; b < 4; b++)
          if (ent_be[head + AW'(i)][b]) begin
            fwd_byte_en[b] = 1'b1;
            fwd_data[8*b +: 8] = ent_data[head + AW'(i)][8*b +: 8];
          end
  end
endmodule

// File: tb/tb_data_memory_store_buffer.sv
// tb_data_memory_store_buffer: directed and random checks of the store buffer against a queue model
module tb_data_memory_store_buffer;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 1;
  logic store_valid = 0, mem_ready = 0;
  logic [31:0] store_addr = 0, store_data = 0, load_addr = 0;
  logic [3:0] store_byte_en = 0;
  logic store_ready, mem_write_en, buffer_empty;
  logic [29:0] mem_addr;
  logic [3:0] mem_byte_en, fwd_byte_en;
  logic [31:0] mem_write_data, fwd_data;
  int passed = 0, total = 0;
  typedef struct {logic [29:0] a; logic [3:0] be; logic [31:0] d;} ent_t;
  ent_t q[$];
  data_memory_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .store_valid(store_valid), .store_ready(store_ready),
    .store_addr(store_addr), .store_byte_en(store_byte_en), .store_data(store_data),
    .mem_write_en(mem_write_en), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_byte_en(mem_byte_en), .mem_write_data(mem_write_data), .load_addr(load_addr),
    .fwd_byte_en(fwd_byte_en), .fwd_data(fwd_data), .buffer_empty(buffer_empty)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic check_model();
    logic [3:0] fb;
    logic [31:0] fd;
    bit e;
    e = q.size() == 0;
    fb = 0;
    fd = 0;
    foreach (q[k])
      if (q[k].a == load_addr[31:2])
        for (int b = 0; b < 4; b++)
          if (q[k].be[b]) begin
            fb[b] = 1'b1;
            fd[8*b +: 8] = q[k].d[8*b +: 8];
          end
    chk("store_ready", 32'(store_ready), 32'(q.size() < DEPTH));
    chk("buffer_empty", 32'(buffer_empty), 32'(e));
    chk("mem_write_en", 32'(mem_write_en), 32'(!e));
    chk("mem_addr", 32'(mem_addr), e ? 0 : 32'(q[0].a));
    chk("mem_byte_en", 32'(mem_byte_en), e ? 0 : 32'(q[0].be));
    chk("mem_write_data", mem_write_data, e ? 0 : q[0].d);
    chk("fwd_byte_en", 32'(fwd_byte_en), 32'(fb));
    chk("fwd_data", fwd_data, fd);
  endtask
  task automatic update_model();
    int n;
    bit dr, acc, mg;
    ent_t e;
    n = q.size();
    dr = n > 0 && mem_ready;
    acc = store_valid && n < DEPTH && store_byte_en != 0;
    mg = 0;
`ifdef STORE_COALESCE_EN
    mg = acc && n > 0 && q[n-1].a == store_addr[31:2] && !(n == 1 && dr);
`endif
    if (reset) q.delete();
    else begin
      if (dr) void'(q.pop_front());
      if (mg) begin
        e = q[q.size()-1];
        e.be = e.be | store_byte_en;
        for (int b = 0; b < 4; b++)
          if (store_byte_en[b]) e.d[8*b +: 8] = store_data[8*b +: 8];
        q[q.size()-1] = e;
      end else if (acc) begin
        e.a = store_addr[31:2];
        e.be = store_byte_en;
        e.d = store_data;
        q.push_back(e);
      end
    end
  endtask
  task automatic step();
    #1;
    check_model();
    @(posedge clk);
    update_model();
    #1;
  endtask
  task automatic st(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    store_valid = 1;
    store_addr = a;
    store_byte_en = be;
    store_data = d;
  endtask
  task automatic do_reset();
    reset = 1;
    store_valid = 0;
    step();
    reset = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    #1;
    chk("rst_store_ready", 32'(store_ready), 1);
    chk("rst_mem_write_en", 32'(mem_write_en), 0);
    chk("rst_buffer_empty", 32'(buffer_empty), 1);
    chk("rst_fwd_byte_en", 32'(fwd_byte_en), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    mem_ready = 1;
    st(32'h100, 4'b0001, 32'hAAAAAAAA);
    step();
    store_valid = 0;
    #1;
    chk("t1_mem_write_en", 32'(mem_write_en), 1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h40);
    chk("t1_mem_byte_en", 32'(mem_byte_en), 32'b0001);
    step();
    chk("t1_empty_after", 32'(buffer_empty), 1);
    mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      st(32'h400 + 32'(4*i), 4'b1111, 32'h1000 + 32'(i));
      step();
    end
    chk("t2_full_not_ready", 32'(store_ready), 0);
    st(32'h500, 4'b1111, 32'h5555);
    step();
    mem_ready = 1;
    step();
    chk("t2_ready_after_drain", 32'(store_ready), 1);
    step();
    store_valid = 0;
    repeat (5) step();
    chk("t2_drained", 32'(buffer_empty), 1);
    do_reset();
    mem_ready = 0;
    st(32'h200, 4'b0011, 32'h11111111);
    step();
    st(32'h202, 4'b1100, 32'h22222222);
    step();
    st(32'h200, 4'b0001, 32'h33333333);
    step();
    store_valid = 0;
    load_addr = 32'h200;
    #1;
    chk("t3_fwd_byte_en", 32'(fwd_byte_en), 32'hF);
    chk("t3_fwd_data", fwd_data, 32'h22221133);
    step();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      st(32'h600 + 32'(4*i), 4'b1111, 32'h6000 + 32'(i));
      step();
    end
    st(32'h700, 4'b1111, 32'h7777);
    mem_ready = 1;
    step();
    store_valid = 0;
    mem_ready = 0;
    #1;
    chk("t4_ready_after", 32'(store_ready), 1);
    chk("t4_head_second", 32'(mem_addr), 32'h181);
    step();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      st(32'h800 + 32'(4*i), 4'b1111, 32'h8000 + 32'(i));
      step();
    end
    store_valid = 0;
    mem_ready = 1;
    reset = 1;
    step();
    reset = 0;
    #1;
    chk("t5_mem_write_en", 32'(mem_write_en), 0);
    chk("t5_buffer_empty", 32'(buffer_empty), 1);
    repeat (3) step();
    mem_ready = 0;
    st(32'h300, 4'b0001, 32'h000000A1);
    step();
    st(32'h300, 4'b0100, 32'h00B20000);
    step();
    store_valid = 0;
    #1;
`ifdef STORE_COALESCE_EN
    chk("t6_mem_byte_en", 32'(mem_byte_en), 32'b0101);
`else
    chk("t6_mem_byte_en", 32'(mem_byte_en), 32'b0001);
`endif
    mem_ready = 1;
    step();
    mem_ready = 0;
    #1;
`ifdef STORE_COALESCE_EN
    chk("t6_count_empty", 32'(buffer_empty), 1);
`else
    chk("t6_count_empty", 32'(buffer_empty), 0);
`endif
    step();
    for (int n = 0; n < 400; n++) begin
      reset = $urandom_range(0, 49) == 0;
      store_valid = $urandom_range(0, 3) != 0;
      store_addr = {27'h0, 3'($urandom_range(0, 3)), 2'($urandom)};
      store_byte_en = 4'($urandom);
      store_data = $urandom;
      mem_ready = $urandom_range(0, 2) == 0;
      load_addr = {27'h0, 3'($urandom_range(0, 3)), 2'($urandom)};
      step();
    end
    reset = 0;
    store_valid = 0;
    mem_ready = 1;
    repeat (DEPTH + 1) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
